// File: rtl/compress_exp_detect.sv
// Per-packet block-exponent detector: ORs one's-complement magnitudes over a packet and
// reports the largest safe left shift 3 cycles after eop. Optional macro COMPRESS_EXP_GUARD_EN.
module compress_exp_detect #(
  parameter int unsigned IW        = 40,
  parameter int unsigned PKT_LEN   = 1584,
  parameter int unsigned MAX_SHIFT = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_sop,
  input  logic          i_eop,
  input  logic          i_vld,
  input  logic [IW-1:0] i_din_re,
  input  logic [IW-1:0] i_din_im,
  output logic [5:0]    o_shift_num,
  output logic          o_shift_vld,
  output logic          o_len_err
);

  localparam int unsigned MW  = IW - 1;
  localparam int unsigned CW  = $clog2(PKT_LEN + 1) + 1;
  localparam int unsigned LZW = 6;

  typedef enum logic {IDLE, ACC} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   m_re_c, m_im_c, m_c;
  logic [MW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            launch_c;

  logic            s1_vld_q;
  logic [MW-1:0]   s1_acc_q;
  logic [CW-1:0]   s1_cnt_q;
  logic [LZW-1:0]  lz_c;
  logic            s2_vld_q;
  logic [LZW-1:0]  s2_lz_q;
  logic            s2_err_q;
  logic [LZW-1:0]  adj_c, shift_c;
  logic [5:0]      shift_num_q;
  logic            shift_vld_q, len_err_q;

  // Sign bit is dropped: the one's-complement magnitude never sets it.
  assign m_re_c = i_din_re[MW-1:0] ^ {MW{i_din_re[IW-1]}};
  assign m_im_c = i_din_im[MW-1:0] ^ {MW{i_din_im[IW-1]}};
  assign m_c    = m_re_c | m_im_c;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_vld && i_sop && !i_eop) state_d = ACC;
      ACC:     if (i_vld && i_eop)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulator update; an sop always restarts, discarding any partial packet.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    launch_c = 1'b0;
    if (i_vld) begin
      if (i_sop) begin
        acc_d    = m_c;
        cnt_d    = CW'(1);
        launch_c = i_eop;
      end else if (state_q == ACC) begin
        acc_d    = acc_q | m_c;
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        launch_c = i_eop;
      end
    end
  end

  always_comb begin
    lz_c = LZW'(MW);
    for (int unsigned i = 0; i < MW; i++) begin
      if (s1_acc_q[i]) lz_c = LZW'(MW - 1 - i);
    end
  end

  always_comb begin
`ifdef COMPRESS_EXP_GUARD_EN
    adj_c = (s2_lz_q == '0) ? '0 : s2_lz_q - LZW'(1);
`else
    adj_c = s2_lz_q;
`endif
    shift_c = (adj_c > LZW'(MAX_SHIFT)) ? LZW'(MAX_SHIFT) : adj_c;
  end

  // Finalize pipeline runs independently of accumulation; reset cancels it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_acc_q    <= '0;
      s1_cnt_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_lz_q     <= '0;
      s2_err_q    <= 1'b0;
      shift_num_q <= '0;
      shift_vld_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      s1_vld_q <= launch_c;
      if (launch_c) begin
        s1_acc_q <= acc_d;
        s1_cnt_q <= cnt_d;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_lz_q  <= lz_c;
        s2_err_q <= (s1_cnt_q != CW'(PKT_LEN));
      end
      shift_vld_q <= s2_vld_q;
      len_err_q   <= s2_vld_q & s2_err_q;
      if (s2_vld_q) shift_num_q <= 6'(shift_c);
    end
  end

  assign o_shift_num = shift_num_q;
  assign o_shift_vld = shift_vld_q;
  assign o_len_err   = len_err_q;

endmodule

// File: tb/tb_compress_exp_detect.sv
// Scoreboard bench for compress_exp_detect; honours COMPRESS_EXP_GUARD_EN in its expectations.
module tb_compress_exp_detect;

  localparam int unsigned IW        = 40;
  localparam int unsigned PKT_LEN   = 1584;
  localparam int unsigned MAX_SHIFT = 24;

  typedef struct {
    int unsigned shift;
    int unsigned len_err;
    int unsigned cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_sop = 1'b0, i_eop = 1'b0, i_vld = 1'b0;
  logic [IW-1:0] i_din_re = '0, i_din_im = '0;
  logic [5:0]    o_shift_num;
  logic          o_shift_vld, o_len_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];
  logic [5:0] prev_shift = '0;

  compress_exp_detect #(.IW(IW), .PKT_LEN(PKT_LEN), .MAX_SHIFT(MAX_SHIFT)) dut (
    .clk(clk), .rst(rst), .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .i_din_re(i_din_re), .i_din_im(i_din_im),
    .o_shift_num(o_shift_num), .o_shift_vld(o_shift_vld), .o_len_err(o_len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0d exp=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected shift from the leading-zero count of the packet's largest magnitude.
  function automatic int unsigned exp_sh(input int unsigned lz);
    int unsigned l;
`ifdef COMPRESS_EXP_GUARD_EN
    l = (lz > 0) ? lz - 1 : 0;
`else
    l = lz;
`endif
    return (l > MAX_SHIFT) ? MAX_SHIFT : l;
  endfunction

  // Random filler whose one's-complement magnitude stays below 2^fb.
  function automatic logic [IW-1:0] filler(input int unsigned fb);
    logic [IW-1:0] x;
    if (fb == 0) return '0;
    x = IW'($urandom_range(0, (1 << fb) - 1));
    if ($urandom_range(0, 1) == 1) x = ~x;
    return x;
  endfunction

  task automatic smp(input logic sop, input logic eop, input logic [IW-1:0] re,
                     input logic [IW-1:0] im, input bit push, input int unsigned sh,
                     input int unsigned err);
    exp_t e;
    i_vld = 1'b1; i_sop = sop; i_eop = eop; i_din_re = re; i_din_im = im;
    if (push) begin
      e.shift = sh; e.len_err = err; e.cyc = cyc + 3;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    i_vld = 1'b0; i_sop = 1'($urandom); i_eop = 1'($urandom);
    i_din_re = {8'hff, 32'($urandom)}; i_din_im = {8'h7f, 32'($urandom)};
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input int len, input int sidx, input logic [IW-1:0] sre,
                          input logic [IW-1:0] sim, input int unsigned fb,
                          input int unsigned lz, input bit push, input bit with_eop,
                          input bit gaps);
    logic [IW-1:0] re, im;
    for (int i = 0; i < len; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 15) == 0) idle(1);
      re = filler(fb); im = filler(fb);
      if (i == sidx) begin re = sre; im = sim; end
      smp(i == 0, with_eop && (i == len - 1), re, im, push && with_eop && (i == len - 1),
          exp_sh(lz), (len != PKT_LEN) ? 1 : 0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_shift <= '0;
    end else begin
      if (o_shift_vld) begin
        if (sb.size() == 0) begin
          check("spurious_vld", 64'(o_shift_vld), 64'd0);
        end else begin
          e = sb.pop_front();
          check("shift_num", 64'(o_shift_num), 64'(e.shift));
          check("len_err", 64'(o_len_err), 64'(e.len_err));
          check("vld_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        check("hold_shift", 64'(o_shift_num), 64'(prev_shift));
      end
      prev_shift <= o_shift_num;
    end
  end

  initial begin
    idle(3);
    rst = 1'b0;
    check("rst_shift", 64'(o_shift_num), 64'd0);
    check("rst_vld", 64'(o_shift_vld), 64'd0);
    check("rst_err", 64'(o_len_err), 64'd0);

    // Samples outside a packet must be ignored.
    smp(1'b0, 1'b0, 40'h40_0000_0000, 40'h7f_ffff_ffff, 0, 0, 0);
    smp(1'b0, 1'b1, 40'h40_0000_0000, 40'h00_0000_0000, 0, 0, 0);
    idle(2);

    send_pkt(PKT_LEN, 700, 40'h00_4000_0000, 40'h0, 10, 8, 1, 1, 1);
    send_pkt(PKT_LEN, 33, 40'h0, 40'hC0_0000_0000, 20, 1, 1, 1, 1);
    send_pkt(PKT_LEN, 33, 40'h0, 40'h80_0000_0000, 20, 0, 1, 1, 1);
    send_pkt(PKT_LEN, -1, 40'h0, 40'h0, 0, 39, 1, 1, 1);
    idle(4);

    // Back-to-back packets, then a short packet.
    send_pkt(PKT_LEN, 1000, 40'hff_bfff_ffff, 40'h0, 12, 8, 1, 1, 0);
    send_pkt(PKT_LEN, 5, 40'h0, 40'h00_0010_0000, 12, 18, 1, 1, 0);
    send_pkt(100, 50, 40'h00_0200_0000, 40'h0, 8, 13, 1, 1, 1);

    // Restart: the first segment (bit 37) must not influence the result.
    send_pkt(500, 10, 40'h20_0000_0000, 40'h0, 16, 1, 0, 0, 1);
    send_pkt(PKT_LEN, 900, 40'h00_4000_0000, 40'h0, 10, 8, 1, 1, 1);

    // Single-sample packets every cycle.
    smp(1'b1, 1'b1, 40'h00_4000_0000, 40'h0, 1, exp_sh(8), 1);
    smp(1'b1, 1'b1, 40'h0, 40'h0, 1, exp_sh(39), 1);
    smp(1'b1, 1'b1, 40'h40_0000_0000, 40'h0, 1, exp_sh(0), 1);
    smp(1'b1, 1'b1, 40'hff_ffff_ffff, 40'h00_0000_0400, 1, exp_sh(28), 1);

    // Over-long packet exercises count saturation.
    send_pkt(4200, 3000, 40'h00_0000_0400, 40'h0, 6, 28, 1, 1, 0);
    idle(6);

    // Reset at T+1 cancels the in-flight result.
    send_pkt(PKT_LEN, 200, 40'h00_4000_0000, 40'h0, 10, 8, 1, 1, 0);
    idle(6);
    send_pkt(PKT_LEN, 200, 40'h00_0010_0000, 40'h0, 10, 18, 0, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_shift", 64'(o_shift_num), 64'd0);
    check("post_rst_vld", 64'(o_shift_vld), 64'd0);
    idle(6);
    send_pkt(PKT_LEN, 1583, 40'h00_0010_0000, 40'h0, 10, 18, 1, 1, 1);

    idle(8);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
